cache_fill_arbiter: RTL and testbench
=====================================

# cache_fill_arbiter

Shared memory-side controller between the I-cache (fetch stage) and D-cache (memory stage) and the single pipelined main memory. It arbitrates cache misses and write-through stores, issues eight word reads per 16-byte block fill, and streams returned words into the requesting cache's data array. On the last word it also writes that cache's tag array. Each fill-busy output stalls the corresponding pipeline stage.

## Interface
- ADDR_W, 16, byte-address width
- DATA_W, 16, word width
- WORDS, 8, words per block; block = 16 bytes
- MEM_LAT, 4, memory read latency in cycles; memory accepts one request per cycle
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- i_miss  in  1  I-cache miss (level, held until the tag is written)
- i_miss_addr  in  ADDR_W  I-cache miss byte address
- d_miss  in  1  D-cache miss (level)
- d_miss_addr  in  ADDR_W  D-cache miss byte address
- d_wr_req  in  1  write-through store request (level, held until acked)
- d_wr_addr  in  ADDR_W  store byte address
- d_wr_data  in  DATA_W  store data
- d_wr_ack  out  1  store accepted by memory this cycle
- i_fill_busy, d_fill_busy  out  1  fill in progress for that cache
- i_data_we, d_data_we  out  1  data-array word write strobe
- i_tag_we, d_tag_we  out  1  tag-array write strobe
- fill_addr  out  ADDR_W  byte address of the word being written
- fill_data  out  DATA_W  word being written (mem_rdata passthrough)
- mem_en  out  1  memory request valid
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  mem_rdata valid; exactly MEM_LAT cycles after a read issue

## Operation
- States: IDLE, FILL_I, FILL_D. All outputs are 0 in reset and in IDLE unless stated otherwise.
- IDLE priority, evaluated each cycle:
  - d_miss: latch base = d_miss_addr & ~0xF, go to FILL_D.
  - Else d_wr_req: combinationally drive mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1. Stay in IDLE.
  - Else i_miss: latch base from i_miss_addr, go to FILL_I.
- A store-miss (d_miss and d_wr_req both high) fills first. The store is acked in a later IDLE cycle.
- FILL_x:
  - x_fill_busy=1.
  - Issue counter iss (0..8): while iss<8, mem_en=1, mem_wr=0, mem_addr=base+2*iss, and iss increments. At iss=8, mem_en=0.
  - Receive counter rcv (0..7): on mem_rvalid, x_data_we=1, fill_addr=base+2*rcv, fill_data=mem_rdata, and rcv increments.
  - On the rvalid where rcv=7, x_tag_we=1 in the same cycle. Next state is IDLE, with iss and rcv cleared.
- The other cache's strobes stay 0 throughout. d_wr_ack is 0 in FILL states. A miss raised by the other cache waits in IDLE.
- mem_rvalid in IDLE is ignored, with no strobes.
- Address arithmetic: ADDR_W bits. base is 16-byte aligned, so base+2*k never carries past bit 3.
- Reset mid-fill: immediately IDLE, counters 0, all outputs 0. The cache re-raises its miss afterwards.

## Timing
- Miss seen in IDLE at cycle 0 → FILL at cycle 1.
- Read issues in cycles 1–8 (addresses base..base+14).
- rvalid in cycles 5–12 with MEM_LAT=4; i.e. the last word arrives at cycle 8+MEM_LAT.
- tag_we in cycle 12; IDLE in cycle 13; busy is high in cycles 1–12.
- Store ack: same cycle as the request when IDLE with no d_miss. Otherwise it is delayed until such a cycle.
- Back-to-back: a miss still asserted in the first IDLE cycle after a fill starts a new fill the next cycle. There is one IDLE cycle minimum between fills.

## Structure
- Package cache_pkg:
  - fill_state_t enum {IDLE, FILL_I, FILL_D}
  - constants BLOCK_BYTES=16, WORDS=8, MEM_LAT=4, OFFSET_MASK=16'hFFF0
  - shared with both caches and the memory model
- Sub-module fill_counter: parameterised-width up-counter with enable, synchronous clear, and async reset. Instantiated twice, for iss and rcv.

## Test plan
- D-miss at 0x1234, memory holds word k = 0xA000+k at block 0x1230 → reads at 0x1230..0x123E in cycles 1–8. d_data_we in cycles 5–12 with fill_data 0xA000..0xA007. d_tag_we in cycle 12. d_fill_busy high in cycles 1–12.
- i_miss and d_miss both high in the same cycle (0x0040 / 0x8000) → D fill completes first (busy 12 cycles), then I fill of block 0x0040 starts the cycle after IDLE. i_data_we never fires during the D fill.
- d_wr_req at 0x2002, data 0xBEEF, in IDLE → same-cycle mem_en=1, mem_wr=1, d_wr_ack=1. Held during an I fill → ack is 0 until the first IDLE cycle.
- Store-miss: d_miss and d_wr_req at 0x3000 together → full fill first, then a one-cycle write with ack.
- rst asserted at cycle 6 of a fill → outputs 0 immediately. mem_rvalid pulses afterwards produce no strobes. A re-raised miss refills all 8 words.
- Spurious mem_rvalid=1 in IDLE → no data_we or tag_we, state unchanged.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache fill arbiter, the caches and the memory model.
package cache_pkg;
  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned WORDS       = 8;
  localparam int unsigned MEM_LAT     = 4;
  localparam logic [15:0] OFFSET_MASK = ~16'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL_I,
    FILL_D
  } fill_state_t;
endpackage

// File: rtl/fill_counter.sv
// Up-counter with enable, synchronous clear (priority over enable) and async reset.
module fill_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache block fills and D-cache write-through stores onto one pipelined memory.
module cache_fill_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              i_fill_busy,
  output logic              d_fill_busy,
  output logic              i_data_we,
  output logic              d_data_we,
  output logic              i_tag_we,
  output logic              d_tag_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);
  localparam int unsigned ISS_W = $clog2(WORDS + 1);
  localparam int unsigned RCV_W = $clog2(WORDS);

  fill_state_t       r_state, w_next;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic [ADDR_W-1:0] w_mask;
  logic [ISS_W-1:0]  w_iss;
  logic [RCV_W-1:0]  w_rcv;
  logic              w_fill, w_iss_en, w_rcv_en, w_last;

  assign w_mask   = ADDR_W'(OFFSET_MASK);
  assign w_fill   = (r_state != IDLE);
  assign w_iss_en = w_fill && (w_iss < ISS_W'(WORDS));
  assign w_rcv_en = w_fill && mem_rvalid;
  assign w_last   = w_rcv_en && (w_rcv == RCV_W'(WORDS - 1));

  fill_counter #(.W(ISS_W)) u_iss (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_iss_en),
    .i_clr   (w_last),
    .o_count (w_iss)
  );

  fill_counter #(.W(RCV_W)) u_rcv (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_rcv_en),
    .i_clr   (w_last),
    .o_count (w_rcv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_base  <= '0;
    end else begin
      r_state <= w_next;
      r_base  <= w_base_nxt;
    end
  end

  // Outputs follow state and memory inputs within the cycle; everything is forced low during reset.
  always_comb begin
    w_next      = r_state;
    w_base_nxt  = r_base;
    d_wr_ack    = 1'b0;
    i_fill_busy = 1'b0;
    d_fill_busy = 1'b0;
    i_data_we   = 1'b0;
    d_data_we   = 1'b0;
    i_tag_we    = 1'b0;
    d_tag_we    = 1'b0;
    fill_addr   = '0;
    fill_data   = '0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (d_miss) begin
            w_next     = FILL_D;
            w_base_nxt = d_miss_addr & w_mask;
          end else if (d_wr_req) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_wr_addr;
            mem_wdata = d_wr_data;
            d_wr_ack  = 1'b1;
          end else if (i_miss) begin
            w_next     = FILL_I;
            w_base_nxt = i_miss_addr & w_mask;
          end
        end
        FILL_I, FILL_D: begin
          i_fill_busy = (r_state == FILL_I);
          d_fill_busy = (r_state == FILL_D);
          if (w_iss_en) begin
            mem_en   = 1'b1;
            mem_addr = r_base + ADDR_W'({w_iss, 1'b0});
          end
          if (mem_rvalid) begin
            fill_addr = r_base + ADDR_W'({w_rcv, 1'b0});
            fill_data = mem_rdata;
            i_data_we = (r_state == FILL_I);
            d_data_we = (r_state == FILL_D);
            if (w_last) begin
              i_tag_we = (r_state == FILL_I);
              d_tag_we = (r_state == FILL_D);
              w_next   = IDLE;
            end
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter with a fixed-latency pipelined memory model.
module tb_cache_fill_arbiter;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic        d_wr_ack, i_fill_busy, d_fill_busy, i_data_we, d_data_we, i_tag_we, d_tag_we;
  logic [15:0] fill_addr, fill_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr, mem_rvalid;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        is_d;
    logic [15:0] addr;
    logic [15:0] data;
  } fill_t;
  fill_t sb[$];

  logic        pv [MEM_LAT] = '{default: 1'b0};
  logic [15:0] pa [MEM_LAT] = '{default: 16'h0};
  logic        spur = 1'b0;
  logic [15:0] spur_data = '0;

  cache_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .i_fill_busy(i_fill_busy), .d_fill_busy(d_fill_busy),
    .i_data_we(i_data_we), .d_data_we(d_data_we),
    .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if ((a & 16'hFFF0) == 16'h1230) return 16'hA000 + 16'(a[3:1]);
    return a ^ 16'h5A5A;
  endfunction

  // Memory returns a read exactly MEM_LAT cycles after it was issued.
  always @(posedge clk) begin
    pv[0] <= mem_en && !mem_wr;
    pa[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end

  assign mem_rvalid = pv[MEM_LAT-1] | spur;
  assign mem_rdata  = spur ? spur_data : (pv[MEM_LAT-1] ? mem_word(pa[MEM_LAT-1]) : 16'h0);

  // Every data-array write must match the next expected word in order.
  always @(negedge clk) begin
    fill_t e;
    if (!rst && (i_data_we || d_data_we)) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL data_we_unexpected i_we=%0b d_we=%0b addr=%h data=%h required=no strobe",
                 i_data_we, d_data_we, fill_addr, fill_data);
      end else begin
        e = sb.pop_front();
        if (d_data_we !== e.is_d || i_data_we !== !e.is_d || fill_addr !== e.addr || fill_data !== e.data)
          $display("FAIL fill_word got i=%0b d=%0b addr=%h data=%h required d=%0b addr=%h data=%h",
                   i_data_we, d_data_we, fill_addr, fill_data, e.is_d, e.addr, e.data);
        else n_pass++;
      end
    end
  end

  function automatic logic [8:0] ctl_vec();
    return {i_fill_busy, d_fill_busy, mem_en, mem_wr, i_data_we, d_data_we, i_tag_we, d_tag_we, d_wr_ack};
  endfunction

  // One fill with miss raised at cycle 0; optional store raised at st_cyc, optional reset at abort_at.
  task automatic do_fill(input bit is_d, input logic [15:0] addr, input bit other,
                         input logic [15:0] oaddr, input int st_cyc, input int abort_at);
    logic [15:0] base;
    logic [8:0]  expv, obs;
    bit          busy, en, we, tg;
    base = addr & OFFSET_MASK;
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        if (is_d) begin
          d_miss = 1'b1; d_miss_addr = addr; i_miss = other; i_miss_addr = oaddr;
        end else begin
          i_miss = 1'b1; i_miss_addr = addr; d_miss = other; d_miss_addr = oaddr;
        end
        for (int k = 0; k < int'(WORDS); k++)
          sb.push_back('{is_d, base + 16'(2 * k), mem_word(base + 16'(2 * k))});
      end
      if (c == st_cyc) d_wr_req = 1'b1;
      if (c == abort_at) rst = 1'b1;
      @(negedge clk);
      busy = (c >= 1);
      en   = (c >= 1) && (c <= 8);
      we   = (c >= 1 + int'(MEM_LAT));
      tg   = (c == 12);
      if (c == abort_at) begin
        busy = 0; en = 0; we = 0; tg = 0;
      end
      expv = {!is_d && busy, is_d && busy, en, 1'b0, !is_d && we, is_d && we, !is_d && tg, is_d && tg, 1'b0};
      obs  = ctl_vec();
      n_total++;
      if (obs !== expv) $display("FAIL fill_ctl cycle=%0d got=%b required=%b", c, obs, expv);
      else n_pass++;
      if (en) begin
        n_total++;
        if (mem_addr !== base + 16'(2 * (c - 1)))
          $display("FAIL fill_rd_addr cycle=%0d got=%h required=%h", c, mem_addr, base + 16'(2 * (c - 1)));
        else n_pass++;
      end
      if (c == abort_at) begin
        n_total++;
        if ({fill_addr, fill_data, mem_addr, mem_wdata} !== 64'h0)
          $display("FAIL reset_buses got=%h required=0", {fill_addr, fill_data, mem_addr, mem_wdata});
        else n_pass++;
        sb.delete();
        return;
      end
    end
  endtask

  // One IDLE cycle with misses dropped; optionally raises a store, checks whether it is acked.
  task automatic idle_cycle(input bit st, input bit exp_ack, input logic [15:0] a, input logic [15:0] d);
    logic [8:0] expv;
    @(posedge clk); #1;
    i_miss = 1'b0; d_miss = 1'b0;
    if (st) begin
      d_wr_req = 1'b1; d_wr_addr = a; d_wr_data = d;
    end
    @(negedge clk);
    expv = {2'b00, exp_ack, exp_ack, 4'b0000, exp_ack};
    n_total++;
    if (ctl_vec() !== expv) $display("FAIL idle_ctl got=%b required=%b", ctl_vec(), expv);
    else n_pass++;
    if (exp_ack) begin
      n_total++;
      if (mem_addr !== a || mem_wdata !== d)
        $display("FAIL store_bus got addr=%h data=%h required addr=%h data=%h", mem_addr, mem_wdata, a, d);
      else n_pass++;
      d_wr_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    d_wr_req = 1'b1; d_wr_addr = 16'h1111; d_wr_data = 16'h2222; d_miss = 1'b1;
    @(negedge clk);
    n_total++;
    if (ctl_vec() !== 9'h0) $display("FAIL reset_ctl got=%b required=0", ctl_vec());
    else n_pass++;
    n_total++;
    if ({fill_addr, fill_data, mem_addr, mem_wdata} !== 64'h0)
      $display("FAIL reset_buses got=%h required=0", {fill_addr, fill_data, mem_addr, mem_wdata});
    else n_pass++;
    @(posedge clk); #1;
    d_wr_req = 1'b0; d_miss = 1'b0; rst = 1'b0;
    idle_cycle(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_d_fill();
    do_fill(1, 16'h1234, 0, 16'h0, -1, -1);
    idle_cycle(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_back_to_back();
    do_fill(1, 16'h8000, 1, 16'h0040, -1, -1);
    do_fill(0, 16'h0040, 0, 16'h0, -1, -1);
    idle_cycle(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_store();
    idle_cycle(1, 1, 16'h2002, 16'hBEEF);
    idle_cycle(0, 0, 16'h0, 16'h0);
    d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF;
    do_fill(0, 16'h0100, 0, 16'h0, 1, -1);
    idle_cycle(0, 1, 16'h2002, 16'hBEEF);
    idle_cycle(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_store_miss();
    d_wr_addr = 16'h3000; d_wr_data = 16'h1357;
    do_fill(1, 16'h3000, 0, 16'h0, 0, -1);
    idle_cycle(0, 1, 16'h3000, 16'h1357);
    idle_cycle(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_reset_midfill();
    do_fill(1, 16'h1234, 0, 16'h0, -1, 6);
    @(posedge clk); #1;
    d_miss = 1'b0;
    @(negedge clk);
    n_total++;
    if (ctl_vec() !== 9'h0) $display("FAIL reset_hold_ctl got=%b required=0", ctl_vec());
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) idle_cycle(0, 0, 16'h0, 16'h0);
    do_fill(1, 16'h1234, 0, 16'h0, -1, -1);
    idle_cycle(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_spurious();
    @(posedge clk); #1;
    spur = 1'b1; spur_data = 16'hDEAD;
    @(negedge clk);
    n_total++;
    if (ctl_vec() !== 9'h0) $display("FAIL spurious_ctl got=%b required=0", ctl_vec());
    else n_pass++;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    n_total++;
    if (ctl_vec() !== 9'h0) $display("FAIL spurious_after got=%b required=0", ctl_vec());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_d_fill();
    test_back_to_back();
    test_store();
    test_store_miss();
    test_reset_midfill();
    test_spurious();
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_drained got=%0d required=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
